// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that borrows the shared ALU from the core.
// The core's ALU request passes through while idle; ADD passes then one MOV pass produce product and flags.
module alu_mul_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic [3:0]   mul_flags,
    input  logic [3:0]   core_alu_ctrl,
    input  logic [N-1:0] core_src_A,
    input  logic [N-1:0] core_src_B,
    output logic [3:0]   alu_ctrl,
    output logic [N-1:0] src_A,
    output logic [N-1:0] src_B,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FLAG = 2'd2
    } state_t;

    localparam logic [3:0] CTRL_ADD = 4'd4;
    localparam logic [3:0] CTRL_MOV = 4'd8;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

    state_t       state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] mcand_q, mcand_d;
    logic [N-1:0] mplier_q, mplier_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [N-1:0] product_q, product_d;
    logic [3:0]   mul_flags_q, mul_flags_d;
    logic         flags_unused;

    assign flags_unused = ^alu_flags[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            product_q   <= '0;
            mul_flags_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            product_q   <= product_d;
            mul_flags_q <= mul_flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        product_d   = product_q;
        mul_flags_d = mul_flags_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = 5'd0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                // Stop as soon as no multiplier bits remain, so k tracks op_b's top set bit.
                if (((mplier_q >> 1) == '0) || (cnt_q == CNT_LAST)) begin
                    state_d = FLAG;
                end else begin
                    state_d = RUN;
                end
            end
            FLAG: begin
                product_d   = alu_result;
                mul_flags_d = {alu_flags[3:2], 2'b00};
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        alu_ctrl = core_alu_ctrl;
        src_A    = core_src_A;
        src_B    = core_src_B;
        case (state_q)
            RUN: begin
                alu_ctrl = CTRL_ADD;
                src_A    = acc_q;
                src_B    = mplier_q[0] ? mcand_q : '0;
            end
            FLAG: begin
                alu_ctrl = CTRL_MOV;
                src_A    = '0;
                src_B    = acc_q;
            end
            default: begin
                alu_ctrl = core_alu_ctrl;
                src_A    = core_src_A;
                src_B    = core_src_B;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign mul_flags = mul_flags_q;

endmodule
